// File: rtl/spi_master_multi.sv
// spi_master_multi: FIFO-buffered SPI master with a per-frame chip select.
// TX words {cs, data} are queued, shifted out in frames of WORDS_PER_FRAME
// words, and received words are queued in an RX FIFO.
//
// Ports:
//   sys_clk, n_rst     : clock, asynchronous active-low reset
//   in_data/in_cs/in_ena : TX word, its chip-select index, write strobe
//   tx_full            : TX FIFO full
//   rdreq/out_data     : RX FIFO pop / show-ahead head (0 when empty)
//   have_msg/len       : RX FIFO not empty / fill level saturated at 255
//   busy               : frame engine active
//   ovf/ovf_clr        : sticky [0] TX overflow, [1] RX drop / clear
//   n_cs/sclk/mosi/miso: SPI pins

module spi_mm_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_i,
    input  logic [W-1:0]            wdata_i,
    input  logic                    rd_i,
    output logic [W-1:0]            head_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_wr;
    logic          do_rd;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_wr   = wr_i && !full_o;
    assign do_rd   = rd_i && (cnt_q != '0);
    assign head_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_rd) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module spi_master_multi #(
    parameter int CPOL            = 0,
    parameter int CPHA            = 0,
    parameter int WORD_W          = 8,
    parameter int WORDS_PER_FRAME = 2,
    parameter int NUM_CS          = 2,
    parameter int CLK_DIV         = 4,
    parameter int CS_GAP          = 2,
    parameter int MSB_FIRST       = 1,
    parameter int FIFO_DEPTH      = 64,
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              sys_clk,
    input  logic              n_rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic [CS_W-1:0]   in_cs,
    input  logic              in_ena,
    output logic              tx_full,
    input  logic              rdreq,
    output logic [WORD_W-1:0] out_data,
    output logic              have_msg,
    output logic [7:0]        len,
    output logic              busy,
    output logic [1:0]        ovf,
    input  logic              ovf_clr,
    output logic [NUM_CS-1:0] n_cs,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);
    localparam int H  = CLK_DIV / 2;
    localparam int FW = CS_W + WORD_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = $clog2(2 * WORD_W + 1);

    localparam logic [15:0]   H_M1   = 16'(H - 1);
    localparam logic [15:0]   GAP_M1 = 16'(CS_GAP - 1);
    localparam logic [EW-1:0] EDGES  = EW'(2 * WORD_W);
    localparam logic [EW-1:0] LAST_S = (CPHA == 0) ? EW'(2 * WORD_W - 1)
                                                   : EW'(2 * WORD_W);
    localparam logic [7:0]    WPF    = 8'(WORDS_PER_FRAME);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [7:0]        word_q, word_d;
    logic              stall_q, stall_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] ncs_q, ncs_d;
    logic [WORD_W-1:0] tx_sh_q, tx_sh_d;
    logic [WORD_W-1:0] rx_sh_q, rx_sh_d;
    logic              rx_push_q, rx_push_d;
    logic [1:0]        ovf_q, ovf_d;

    logic [FW-1:0]     tx_head;
    logic [AW:0]       tx_cnt;
    logic              tx_full_w;
    logic              tx_empty;
    logic              tx_pop;
    logic [WORD_W-1:0] rx_head;
    logic [AW:0]       rx_cnt;
    logic [8:0]        rx_cnt9;
    logic              rx_full;

    logic [EW-1:0]     e_nxt;
    logic              e_sample;
    logic              e_shift;
    logic              head_first;
    logic              sh_first;
    logic              sh_next;

    spi_mm_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk_i   (sys_clk),
        .rst_ni  (n_rst),
        .wr_i    (in_ena),
        .wdata_i ({in_cs, in_data}),
        .rd_i    (tx_pop),
        .head_o  (tx_head),
        .full_o  (tx_full_w),
        .count_o (tx_cnt)
    );

    spi_mm_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk_i   (sys_clk),
        .rst_ni  (n_rst),
        .wr_i    (rx_push_q),
        .wdata_i (rx_sh_q),
        .rd_i    (rdreq),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .count_o (rx_cnt)
    );

    assign tx_empty   = (tx_cnt == '0);
    assign head_first = (MSB_FIRST != 0) ? tx_head[WORD_W-1] : tx_head[0];
    assign sh_first   = (MSB_FIRST != 0) ? tx_sh_q[WORD_W-1] : tx_sh_q[0];
    assign sh_next    = (MSB_FIRST != 0) ? tx_sh_q[WORD_W-2] : tx_sh_q[1];

    // Edge numbering runs 1..2*WORD_W within a word; odd edges are leading.
    assign e_nxt    = edge_q + 1'b1;
    assign e_sample = (CPHA == 0) ? e_nxt[0] : !e_nxt[0];
    assign e_shift  = (CPHA == 0) ? (!e_nxt[0] && e_nxt != EDGES) : e_nxt[0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        word_d    = word_q;
        stall_d   = stall_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ncs_d     = ncs_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_push_d = 1'b0;
        tx_pop    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    edge_d  = '0;
                    stall_d = 1'b0;
                    tx_pop  = 1'b1;
                    tx_sh_d = tx_head[WORD_W-1:0];
                    word_d  = 8'd1;
                    // Out-of-range indices leave every select high.
                    for (int i = 0; i < NUM_CS; i++) begin
                        ncs_d[i] = (tx_head[FW-1 -: CS_W] != CS_W'(i));
                    end
                    if (CPHA == 0) begin
                        mosi_d = head_first;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == H_M1) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SHIFT: begin
                if (stall_q) begin
                    // SCLK parked at idle level until the next word arrives.
                    if (!tx_empty) begin
                        tx_pop  = 1'b1;
                        tx_sh_d = tx_head[WORD_W-1:0];
                        word_d  = word_q + 8'd1;
                        stall_d = 1'b0;
                        cnt_d   = '0;
                        if (CPHA == 0) begin
                            mosi_d = head_first;
                        end
                    end
                end else if (cnt_q != H_M1) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = e_nxt;
                    if (e_sample) begin
                        rx_sh_d = (MSB_FIRST != 0)
                                ? {rx_sh_q[WORD_W-2:0], miso}
                                : {miso, rx_sh_q[WORD_W-1:1]};
                        rx_push_d = (e_nxt == LAST_S);
                    end
                    if (e_shift) begin
                        if (CPHA != 0 && e_nxt == EW'(1)) begin
                            mosi_d = sh_first;
                        end else begin
                            mosi_d  = sh_next;
                            tx_sh_d = (MSB_FIRST != 0)
                                    ? {tx_sh_q[WORD_W-2:0], 1'b0}
                                    : {1'b0, tx_sh_q[WORD_W-1:1]};
                        end
                    end
                    if (e_nxt == EDGES) begin
                        edge_d = '0;
                        if (word_q == WPF) begin
                            state_d = S_HOLD;
                        end else if (!tx_empty) begin
                            tx_pop  = 1'b1;
                            tx_sh_d = tx_head[WORD_W-1:0];
                            word_d  = word_q + 8'd1;
                            if (CPHA == 0) begin
                                mosi_d = head_first;
                            end
                        end else begin
                            stall_d = 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == H_M1) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    ncs_d   = '1;
                    mosi_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_M1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = '0;
        end
        if (in_ena && tx_full_w) begin
            ovf_d[0] = 1'b1;
        end
        if (rx_push_q && rx_full) begin
            ovf_d[1] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            word_q    <= '0;
            stall_q   <= 1'b0;
            sclk_q    <= 1'(CPOL);
            mosi_q    <= 1'b0;
            ncs_q     <= '1;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_push_q <= 1'b0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            word_q    <= word_d;
            stall_q   <= stall_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ncs_q     <= ncs_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_push_q <= rx_push_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rx_cnt9  = 9'(rx_cnt);
    assign len      = (rx_cnt9 > 9'd255) ? 8'hFF : rx_cnt9[7:0];
    assign have_msg = (rx_cnt != '0);
    assign out_data = have_msg ? rx_head : '0;
    assign tx_full  = tx_full_w;
    assign busy     = (state_q != S_IDLE);
    assign ovf      = ovf_q;
    assign n_cs     = ncs_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
endmodule
